// File: rtl/ram_memory_interface_pkg.sv
// Shared sizes, default latencies and FSM state encodings for the RAM-side line interface.
// Benches may import this package to decode the responder state.
package ram_memory_interface_pkg;

   localparam int c_ADDR_TAG_SIZE   = 4;
   localparam int c_ADDR_INDEX_SIZE = 4;
   localparam int c_RAM_DATA_SIZE   = 32;

   localparam int unsigned c_MI_RD_LATENCY = 4;
   localparam int unsigned c_MI_WR_LATENCY = 3;

   typedef logic [1:0] mi_state_t;

   localparam mi_state_t MI_S_IDLE    = 2'd0;
   localparam mi_state_t MI_S_ACCESS  = 2'd1;
   localparam mi_state_t MI_S_ACK     = 2'd2;
   localparam mi_state_t MI_S_RELEASE = 2'd3;

   // A zero latency still needs one edge to move through ACCESS.
   function automatic int unsigned mi_eff_latency(input int unsigned lat);
      return (lat == 0) ? 1 : lat;
   endfunction

   function automatic int unsigned mi_cnt_width(input int unsigned max_lat);
      return (max_lat > 1) ? $clog2(max_lat) : 1;
   endfunction

endpackage

// File: rtl/ram_memory_interface_ram.sv
// Backing line array: synchronous write, registered read; only the read register is reset
// so that stored lines survive a reset.
module mi_backing_ram #(
   parameter int P_ADDR_W = 8,
   parameter int P_DATA_W = 32
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic                re,
   input  logic [P_ADDR_W-1:0] addr,
   input  logic [P_DATA_W-1:0] wdata,
   output logic [P_DATA_W-1:0] rdata
);

   logic [P_DATA_W-1:0] mem [2**P_ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/ram_memory_interface.sv
// Responder side of the cache-to-RAM line transfer: fixed-latency access, four-phase req/ack.
// Optional per-op completion counters under `MI_ACCESS_CNT_EN.
module ram_memory_interface
   import ram_memory_interface_pkg::*;
#(
   parameter int          P_LINE_ADDR_SIZE = c_ADDR_TAG_SIZE + c_ADDR_INDEX_SIZE,
   parameter int          P_DATA_SIZE      = c_RAM_DATA_SIZE,
   parameter int unsigned P_RD_LATENCY     = c_MI_RD_LATENCY,
   parameter int unsigned P_WR_LATENCY     = c_MI_WR_LATENCY
)(
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [P_LINE_ADDR_SIZE-1:0] RAM_LINE_ADDR,
   input  logic                        SIG_RAM_RD,
   input  logic                        SIG_RAM_WR,
   input  logic [P_DATA_SIZE-1:0]      MI_IN_DATA,
   output logic [P_DATA_SIZE-1:0]      MI_OUT_DATA,
   output logic                        MI_SIG_RAM_ACK,
   output logic                        MI_BUSY
`ifdef MI_ACCESS_CNT_EN
   ,
   output logic [15:0]                 MI_RD_CNT,
   output logic [15:0]                 MI_WR_CNT
`endif
);

   localparam int unsigned RD_L  = mi_eff_latency(P_RD_LATENCY);
   localparam int unsigned WR_L  = mi_eff_latency(P_WR_LATENCY);
   localparam int unsigned MAX_L = (RD_L > WR_L) ? RD_L : WR_L;
   localparam int          CNT_W = mi_cnt_width(MAX_L);

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_L - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_L - 1);

   mi_state_t                   state;
   mi_state_t                   state_nxt;
   logic [CNT_W-1:0]            cnt;
   logic                        op_wr;
   logic [P_LINE_ADDR_SIZE-1:0] addr_q;
   logic [P_DATA_SIZE-1:0]      data_q;
   logic                        accept;
   logic                        finish;
   logic                        ram_we;
   logic                        ram_re;

   assign accept = (state == MI_S_IDLE) && (SIG_RAM_RD || SIG_RAM_WR);
   assign finish = (state == MI_S_ACCESS) && (cnt == '0);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= MI_S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MI_S_IDLE:    if (accept) state_nxt = MI_S_ACCESS;
         MI_S_ACCESS:  if (finish) state_nxt = MI_S_ACK;
         MI_S_ACK:     if (!SIG_RAM_RD && !SIG_RAM_WR) state_nxt = MI_S_RELEASE;
         MI_S_RELEASE: state_nxt = MI_S_IDLE;
         default:      state_nxt = MI_S_IDLE;
      endcase
   end

   // ACK is a decode of the registered state, so it rises on the finishing edge.
   always_comb begin
      MI_SIG_RAM_ACK = (state == MI_S_ACK);
      MI_BUSY        = (state != MI_S_IDLE);
      ram_we         = finish && op_wr;
      ram_re         = finish && !op_wr;
   end

   // Write wins when both requests are seen together.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt    <= '0;
         op_wr  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (accept) begin
         op_wr  <= SIG_RAM_WR;
         addr_q <= RAM_LINE_ADDR;
         data_q <= MI_IN_DATA;
         cnt    <= SIG_RAM_WR ? WR_LOAD : RD_LOAD;
      end else if ((state == MI_S_ACCESS) && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   mi_backing_ram #(
      .P_ADDR_W (P_LINE_ADDR_SIZE),
      .P_DATA_W (P_DATA_SIZE)
   ) u_ram (
      .clk   (CLK),
      .rst   (RESET),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (addr_q),
      .wdata (data_q),
      .rdata (MI_OUT_DATA)
   );

`ifdef MI_ACCESS_CNT_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         MI_RD_CNT <= '0;
         MI_WR_CNT <= '0;
      end else begin
         if (ram_re) MI_RD_CNT <= MI_RD_CNT + 16'd1;
         if (ram_we) MI_WR_CNT <= MI_WR_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ram_memory_interface.sv
// Scoreboard bench: stimulus queues expected completions, a negedge monitor checks each ACK rise.
module tb_ram_memory_interface;

   localparam int AW   = 8;
   localparam int DW   = 32;
   localparam int RD_L = 4;
   localparam int WR_L = 3;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [AW-1:0] RAM_LINE_ADDR;
   logic          SIG_RAM_RD;
   logic          SIG_RAM_WR;
   logic [DW-1:0] MI_IN_DATA;
   logic [DW-1:0] MI_OUT_DATA;
   logic          MI_SIG_RAM_ACK;
   logic          MI_BUSY;
`ifdef MI_ACCESS_CNT_EN
   logic [15:0]   MI_RD_CNT;
   logic [15:0]   MI_WR_CNT;
`endif

   ram_memory_interface #(
      .P_LINE_ADDR_SIZE (AW),
      .P_DATA_SIZE      (DW),
      .P_RD_LATENCY     (RD_L),
      .P_WR_LATENCY     (WR_L)
   ) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .RAM_LINE_ADDR  (RAM_LINE_ADDR),
      .SIG_RAM_RD     (SIG_RAM_RD),
      .SIG_RAM_WR     (SIG_RAM_WR),
      .MI_IN_DATA     (MI_IN_DATA),
      .MI_OUT_DATA    (MI_OUT_DATA),
      .MI_SIG_RAM_ACK (MI_SIG_RAM_ACK),
      .MI_BUSY        (MI_BUSY)
`ifdef MI_ACCESS_CNT_EN
      ,
      .MI_RD_CNT      (MI_RD_CNT),
      .MI_WR_CNT      (MI_WR_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit            op_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            accept;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model [int];
   int            written[$];
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            rd_n = 0;
   int            wr_n = 0;
   logic [DW-1:0] exp_out = '0;
   bit            prev_ack = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every ACK rise must match the oldest queued transaction.
   always @(negedge CLK) begin
      if (!RESET) begin
         if (MI_SIG_RAM_ACK && !prev_ack) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", MI_SIG_RAM_ACK, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk(e.op_wr ? "wr_latency" : "rd_latency", cyc - e.accept, e.op_wr ? WR_L : RD_L);
               if (!e.op_wr) exp_out = e.data;
            end
         end
         chk("out_data", MI_OUT_DATA, exp_out);
      end
      prev_ack = MI_SIG_RAM_ACK;
   end

   // Called at posedge+1; acceptance expected acc_off edges later.
   task automatic txn(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int hold, input int acc_off, input bit quick);
      exp_t e;
      int   n;
      SIG_RAM_RD    = rd;
      SIG_RAM_WR    = wr;
      RAM_LINE_ADDR = a;
      MI_IN_DATA    = d;
      e.op_wr  = wr;
      e.addr   = a;
      e.accept = cyc + acc_off;
      if (wr) begin
         model[int'(a)] = d;
         e.data = d;
         written.push_back(int'(a));
         wr_n++;
      end else begin
         e.data = model[int'(a)];
         rd_n++;
      end
      exp_q.push_back(e);
      n = 0;
      do begin
         @(posedge CLK); #1;
         n++;
         if (n >= acc_off) begin
            RAM_LINE_ADDR = AW'($urandom);
            MI_IN_DATA    = $urandom;
         end
      end while (!MI_SIG_RAM_ACK && n < 30);
      chk("ack_seen", MI_SIG_RAM_ACK, 1);
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK); #1;
         chk("hold_ack", MI_SIG_RAM_ACK, 1);
         chk("hold_busy", MI_BUSY, 1);
      end
      SIG_RAM_RD = 1'b0;
      SIG_RAM_WR = 1'b0;
      @(posedge CLK); #1;
      chk("ack_drop", MI_SIG_RAM_ACK, 0);
      chk("release_busy", MI_BUSY, 1);
      if (!quick) begin
         @(posedge CLK); #1;
         chk("idle_busy", MI_BUSY, 0);
      end
   endtask

   task automatic pulse_reset();
      RESET = 1'b1;
      #2;
      chk("rst_ack", MI_SIG_RAM_ACK, 0);
      chk("rst_busy", MI_BUSY, 0);
      chk("rst_out", MI_OUT_DATA, 0);
`ifdef MI_ACCESS_CNT_EN
      chk("rst_rd_cnt", MI_RD_CNT, 0);
      chk("rst_wr_cnt", MI_WR_CNT, 0);
`endif
      RESET    = 1'b0;
      exp_out  = '0;
      prev_ack = 1'b0;
      rd_n     = 0;
      wr_n     = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit q;
      RESET         = 1'b1;
      SIG_RAM_RD    = 1'b0;
      SIG_RAM_WR    = 1'b0;
      RAM_LINE_ADDR = '0;
      MI_IN_DATA    = '0;
      #1;
      chk("init_ack", MI_SIG_RAM_ACK, 0);
      chk("init_busy", MI_BUSY, 0);
      chk("init_out", MI_OUT_DATA, 0);
      @(posedge CLK); @(posedge CLK); #1;
      RESET = 1'b0;

      txn(0, 1, 8'h12, 32'hDEADBEEF, 0, 1, 0);
      txn(1, 0, 8'h12, 32'h0, 0, 1, 0);
      txn(1, 1, 8'h05, 32'hA5A5A5A5, 0, 1, 0);
      txn(1, 0, 8'h05, 32'h0, 0, 1, 0);

      // Long-held read: one transaction only.
      txn(1, 0, 8'h12, 32'h0, 20, 1, 0);
      @(posedge CLK); #1;
      chk("held_no_reaccept", MI_BUSY, 0);

      // Reset during the second ACCESS cycle of a write.
      txn(0, 1, 8'h07, 32'h22222222, 0, 1, 0);
      SIG_RAM_WR    = 1'b1;
      RAM_LINE_ADDR = 8'h07;
      MI_IN_DATA    = 32'h11111111;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      pulse_reset();
      SIG_RAM_WR = 1'b0;
      @(posedge CLK); #1;
      chk("post_rst_idle", MI_BUSY, 0);
      txn(1, 0, 8'h07, 32'h0, 0, 1, 0);

      // Back-to-back reads with the next request raised during RELEASE.
      txn(0, 1, 8'h00, 32'h01234567, 0, 1, 0);
      txn(0, 1, 8'hFF, 32'h89ABCDEF, 0, 1, 0);
      txn(1, 0, 8'h00, 32'h0, 0, 1, 1);
      txn(1, 0, 8'hFF, 32'h0, 1, 2, 0);

      q = 1'b0;
      for (int i = 0; i < 60; i++) begin
         bit do_wr;
         bit quick;
         logic [AW-1:0] a;
         do_wr = ($urandom_range(0, 1) == 1);
         quick = ($urandom_range(0, 2) == 0) && (i != 59);
         if (do_wr) begin
            a = AW'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), 1, a, $urandom, $urandom_range(0, 3), q ? 2 : 1, quick);
         end else begin
            a = AW'(written[$urandom_range(0, written.size() - 1)]);
            txn(1, 0, a, 32'h0, $urandom_range(0, 3), q ? 2 : 1, quick);
         end
         q = quick;
      end

      repeat (5) @(posedge CLK);
      #1;
      chk("queue_empty", exp_q.size(), 0);
`ifdef MI_ACCESS_CNT_EN
      chk("rd_cnt", MI_RD_CNT, 16'(rd_n));
      chk("wr_cnt", MI_WR_CNT, 16'(wr_n));
      pulse_reset();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
